// File: rtl/data_memory_interface_pkg.sv
// Shared definitions for the RV64I data-memory interface: funct3 load/store
// encodings, FSM state encoding and small lane/alignment helpers.
package data_memory_interface_pkg;

  localparam logic [2:0] FUNCT3_LB      = 3'b000;
  localparam logic [2:0] FUNCT3_LH      = 3'b001;
  localparam logic [2:0] FUNCT3_LW      = 3'b010;
  localparam logic [2:0] FUNCT3_LD      = 3'b011;
  localparam logic [2:0] FUNCT3_LBU     = 3'b100;
  localparam logic [2:0] FUNCT3_LHU     = 3'b101;
  localparam logic [2:0] FUNCT3_LWU     = 3'b110;
  localparam logic [2:0] FUNCT3_SB      = 3'b000;
  localparam logic [2:0] FUNCT3_SH      = 3'b001;
  localparam logic [2:0] FUNCT3_SW      = 3'b010;
  localparam logic [2:0] FUNCT3_SD      = 3'b011;
  localparam logic [2:0] FUNCT3_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Byte enables for one 32-bit beat; funct3[1:0] carries the access size.
  function automatic logic [3:0] lane_enables(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] lo);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = (lo[0] != 1'b0);
      2'b10:   mis = (lo[1:0] != 2'b00);
      2'b11:   mis = (lo != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Clears the address bits below the access size (natural alignment).
  function automatic logic [2:0] align_low(input logic [2:0] funct3, input logic [2:0] lo);
    logic [2:0] al;
    case (funct3[1:0])
      2'b00:   al = lo;
      2'b01:   al = {lo[2:1], 1'b0};
      2'b10:   al = {lo[2], 2'b00};
      default: al = 3'b000;
    endcase
    return al;
  endfunction

endpackage

// File: rtl/data_memory_interface_load_extender.sv
// Load result formatting: selects the addressed lane of a 32-bit read beat
// and sign- or zero-extends it to 64 bits according to funct3.
module data_memory_interface_load_extender
  import data_memory_interface_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [63:0] ext_data
);

  logic [31:0] shifted_s;

  // Move the addressed lane down to bit 0, then extend by size and signedness.
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
    case (funct3)
      FUNCT3_LB:  ext_data = {{56{shifted_s[7]}}, shifted_s[7:0]};
      FUNCT3_LH:  ext_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
      FUNCT3_LW:  ext_data = {{32{shifted_s[31]}}, shifted_s};
      FUNCT3_LBU: ext_data = {56'h0, shifted_s[7:0]};
      FUNCT3_LHU: ext_data = {48'h0, shifted_s[15:0]};
      FUNCT3_LWU: ext_data = {32'h0, shifted_s};
      default:    ext_data = 64'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_interface.sv
// Data-memory interface for the RV64I core: turns one load/store into one or
// two 32-bit req/ack bus beats, stalls the core via mem_busy and pulses
// mem_done on completion. A per-beat watchdog ends a hung beat with bus_error.
// Optional feature macro: DATA_MEM_MISALIGN_EXC_EN (misaligned accesses raise
// misaligned_exc instead of being forced to natural alignment).
module data_memory_interface
  import data_memory_interface_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_mem_read_en,
  input  logic                  data_mem_write_en,
  input  logic [2:0]            inst_funct3,
  input  logic [63:0]           address,
  input  logic [63:0]           write_data,
  output logic [63:0]           read_data,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  bus_error,
`ifdef DATA_MEM_MISALIGN_EXC_EN
  output logic                  misaligned_exc,
`endif
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic        WDOG_EN       = (TIMEOUT_LIMIT != 32'd0);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [63:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           wdog_q, wdog_d;
  logic [63:0]           read_data_q, read_data_d;
  logic                  mem_done_q, mem_done_d;
  logic                  bus_error_q, bus_error_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;
  logic [3:0]            bus_be_q, bus_be_d;
`ifdef DATA_MEM_MISALIGN_EXC_EN
  logic                  misaligned_q, misaligned_d;
`endif
  logic                  req_s;
  logic                  timeout_s;
  logic [63:0]           ext_s;
  logic                  unused_addr_s;

  assign req_s         = data_mem_read_en | data_mem_write_en;
  assign timeout_s     = WDOG_EN && ((wdog_q + 32'd1) == TIMEOUT_LIMIT);
  assign unused_addr_s = ^address[63:ADDR_WIDTH];

  data_memory_interface_load_extender u_load_extender (
    .funct3   (funct3_q),
    .lane     (addr_q[1:0]),
    .rdata    (bus_rdata),
    .ext_data (ext_s)
  );

  // Next-state, capture and registered-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    lo_d        = lo_q;
    wdog_d      = wdog_q;
    read_data_d = read_data_q;
    bus_error_d = 1'b0;
`ifdef DATA_MEM_MISALIGN_EXC_EN
    misaligned_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          we_d     = data_mem_write_en;
          funct3_d = inst_funct3;
          addr_d   = {address[ADDR_WIDTH-1:3], align_low(inst_funct3, address[2:0])};
          wdata_d  = write_data;
          wdog_d   = 32'd0;
          if (inst_funct3 == FUNCT3_ILLEGAL) begin
            state_d     = ST_DONE;
            read_data_d = 64'h0;
          end
`ifdef DATA_MEM_MISALIGN_EXC_EN
          else if (is_misaligned(inst_funct3, address[2:0])) begin
            state_d      = ST_DONE;
            read_data_d  = 64'h0;
            misaligned_d = 1'b1;
          end
`endif
          else begin
            state_d = ST_BEAT0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (bus_ack) begin
          wdog_d = 32'd0;
          if (funct3_q == FUNCT3_LD) begin
            state_d = ST_BEAT1;
            lo_d    = bus_rdata;
          end else begin
            state_d = ST_DONE;
            if (!we_q) begin
              read_data_d = ext_s;
            end else begin
              read_data_d = read_data_q;
            end
          end
        end else if (timeout_s) begin
          state_d     = ST_DONE;
          bus_error_d = 1'b1;
          read_data_d = 64'h0;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      ST_BEAT1: begin
        if (bus_ack) begin
          state_d = ST_DONE;
          if (!we_q) begin
            read_data_d = {bus_rdata, lo_q};
          end else begin
            read_data_d = read_data_q;
          end
        end else if (timeout_s) begin
          state_d     = ST_DONE;
          bus_error_d = 1'b1;
          read_data_d = 64'h0;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs follow the next state so they are valid from the first beat cycle.
    bus_req_d = (state_d == ST_BEAT0) || (state_d == ST_BEAT1);
    if (bus_req_d) begin
      bus_we_d = we_d;
      bus_be_d = lane_enables(funct3_d, addr_d[1:0]);
      if (state_d == ST_BEAT1) begin
        bus_addr_d  = {addr_d[ADDR_WIDTH-1:3], 3'b100};
        bus_wdata_d = wdata_d[63:32];
      end else begin
        bus_addr_d  = {addr_d[ADDR_WIDTH-1:2], 2'b00};
        bus_wdata_d = wdata_d[31:0] << {addr_d[1:0], 3'b000};
      end
    end else begin
      bus_we_d    = 1'b0;
      bus_be_d    = 4'b0000;
      bus_addr_d  = '0;
      bus_wdata_d = 32'h0;
    end
    mem_done_d = (state_d == ST_DONE);
  end

  // State, captured request and registered outputs; reset abandons any access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      wdata_q      <= 64'h0;
      we_q         <= 1'b0;
      lo_q         <= 32'h0;
      wdog_q       <= 32'd0;
      read_data_q  <= 64'h0;
      mem_done_q   <= 1'b0;
      bus_error_q  <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= 32'h0;
      bus_be_q     <= 4'b0000;
`ifdef DATA_MEM_MISALIGN_EXC_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      lo_q         <= lo_d;
      wdog_q       <= wdog_d;
      read_data_q  <= read_data_d;
      mem_done_q   <= mem_done_d;
      bus_error_q  <= bus_error_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
`ifdef DATA_MEM_MISALIGN_EXC_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign mem_busy  = ((state_q == ST_IDLE) & req_s) | (state_q == ST_BEAT0) | (state_q == ST_BEAT1);
  assign read_data = read_data_q;
  assign mem_done  = mem_done_q;
  assign bus_error = bus_error_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
`ifdef DATA_MEM_MISALIGN_EXC_EN
  assign misaligned_exc = misaligned_q;
`endif

endmodule

// File: tb/tb_data_memory_interface.sv
// Self-checking bench for data_memory_interface: table of load/store vectors
// driven through a bus responder, expected results queued in a scoreboard,
// plus hand-written sequences for enable hold-over and reset mid-access.
module tb_data_memory_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_mem_read_en, data_mem_write_en;
  logic [2:0]  inst_funct3;
  logic [63:0] address, write_data, read_data;
  logic        mem_busy, mem_done, bus_error;
`ifdef DATA_MEM_MISALIGN_EXC_EN
  logic        misaligned_exc;
`endif
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    int          delay;
    logic [31:0] rd0, rd1;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  be;
    logic [31:0] w0, a1, w1;
    logic [63:0] exp_rd;
    logic        keep;
    int          done_cyc;
    logic        err;
    logic        mis;
  } vec_t;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
    logic        mis;
  } sb_t;

  localparam int NV = 14;
  vec_t        vecs[NV];
  sb_t         sb_q[$];
  logic [63:0] model_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  data_memory_interface #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .data_mem_read_en(data_mem_read_en), .data_mem_write_en(data_mem_write_en),
    .inst_funct3(inst_funct3), .address(address), .write_data(write_data),
    .read_data(read_data), .mem_busy(mem_busy), .mem_done(mem_done), .bus_error(bus_error),
`ifdef DATA_MEM_MISALIGN_EXC_EN
    .misaligned_exc(misaligned_exc),
`endif
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one access, answers bus beats after v.delay wait cycles, checks every cycle.
  task automatic run_vec(input vec_t v, input bit hold);
    int   cyc, wait_n, beat, starts;
    logic acked, done_seen;
    sb_t  e;
    @(negedge clock);
    data_mem_read_en  = ~v.we;
    data_mem_write_en = v.we;
    inst_funct3       = v.f3;
    address           = v.addr;
    write_data        = v.wd;
    bus_ack           = 1'b0;
    e.rd  = v.keep ? model_rd : v.exp_rd;
    e.err = v.err;
    e.mis = v.mis;
    sb_q.push_back(e);
    #1 check("busy_on_request", {63'h0, mem_busy}, 64'h1);
    cyc = 0; wait_n = 0; beat = 0; starts = 0; acked = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (acked) begin
        beat++; wait_n = 0; acked = 1'b0; bus_ack = 1'b0;
      end
      if (mem_done) begin
        done_seen = 1'b1;
        e = sb_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(v.done_cyc));
        check("busy_at_done", {63'h0, mem_busy}, 64'h0);
        check("req_at_done", {63'h0, bus_req}, 64'h0);
        check("read_data", read_data, e.rd);
        check("bus_error", {63'h0, bus_error}, {63'h0, e.err});
`ifdef DATA_MEM_MISALIGN_EXC_EN
        check("misaligned_exc", {63'h0, misaligned_exc}, {63'h0, e.mis});
`endif
        model_rd = e.rd;
      end else if (bus_req) begin
        if (wait_n == 0) starts++;
        check("beat_addr", {32'h0, bus_addr}, {32'h0, (beat == 0) ? v.a0 : v.a1});
        check("beat_wdata", {32'h0, bus_wdata}, {32'h0, (beat == 0) ? v.w0 : v.w1});
        check("beat_be", {60'h0, bus_be}, {60'h0, v.be});
        check("beat_we", {63'h0, bus_we}, {63'h0, v.we});
        check("busy_in_beat", {63'h0, mem_busy}, 64'h1);
        if (wait_n == v.delay) begin
          bus_ack   = 1'b1;
          bus_rdata = (beat == 0) ? v.rd0 : v.rd1;
          acked     = 1'b1;
        end else begin
          bus_rdata = $urandom;
        end
        wait_n++;
      end
    end
    if (!done_seen) begin
      check("done_within_budget", 64'h0, 64'h1);
      void'(sb_q.pop_front());
    end
    check("beat_count", 64'(starts), 64'(v.nbeats));
    if (hold) begin
      @(posedge clock); #1;
      check("no_retrigger_req", {63'h0, bus_req}, 64'h0);
      check("no_retrigger_done", {63'h0, mem_done}, 64'h0);
      check("idle_busy_with_en", {63'h0, mem_busy}, 64'h1);
    end
    @(negedge clock);
    data_mem_read_en  = 1'b0;
    data_mem_write_en = 1'b0;
    bus_ack           = 1'b0;
  endtask

  initial begin
    // we, f3, addr, wd, delay, rd0, rd1, nbeats, a0, be, w0, a1, w1, exp_rd, keep, done, err, mis
    vecs[0]  = '{1'b1, 3'b010, 64'h104, 64'hDEAD_BEEF, 0, 32'h0, 32'h0, 1, 32'h104, 4'hF, 32'hDEAD_BEEF, 32'h0, 32'h0, 64'h0, 1'b1, 2, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 64'h203, 64'h0, 0, 32'h8000_0000, 32'h0, 1, 32'h200, 4'b1000, 32'h0, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 64'h203, 64'h0, 0, 32'h8000_0000, 32'h0, 1, 32'h200, 4'b1000, 32'h0, 32'h0, 32'h0, 64'h80, 1'b0, 2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'b011, 64'h1000, 64'h1122_3344_5566_7788, 0, 32'h0, 32'h0, 2, 32'h1000, 4'hF, 32'h5566_7788, 32'h1004, 32'h1122_3344, 64'h0, 1'b1, 3, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b010, 64'h300, 64'h0, 5, 32'h89AB_CDEF, 32'h0, 1, 32'h300, 4'hF, 32'h0, 32'h0, 32'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 7, 1'b0, 1'b0};
`ifdef DATA_MEM_MISALIGN_EXC_EN
    vecs[5]  = '{1'b0, 3'b001, 64'h101, 64'h0, 0, 32'h0000_8001, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 64'h0, 1'b0, 1, 1'b0, 1'b1};
`else
    vecs[5]  = '{1'b0, 3'b001, 64'h101, 64'h0, 0, 32'h0000_8001, 32'h0, 1, 32'h100, 4'b0011, 32'h0, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 2, 1'b0, 1'b0};
`endif
    vecs[6]  = '{1'b0, 3'b101, 64'h102, 64'h0, 0, 32'hBEEF_0000, 32'h0, 1, 32'h100, 4'b1100, 32'h0, 32'h0, 32'h0, 64'hBEEF, 1'b0, 2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 64'h3, 64'hA5, 0, 32'h0, 32'h0, 1, 32'h0, 4'b1000, 32'hA500_0000, 32'h0, 32'h0, 64'h0, 1'b1, 2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'b001, 64'h12, 64'h1234, 0, 32'h0, 32'h0, 1, 32'h10, 4'b1100, 32'h1234_0000, 32'h0, 32'h0, 64'h0, 1'b1, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'b011, 64'h2000, 64'h0, 2, 32'h1111_2222, 32'h3333_4444, 2, 32'h2000, 4'hF, 32'h0, 32'h2004, 32'h0, 64'h3333_4444_1111_2222, 1'b0, 7, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b110, 64'h40, 64'h0, 0, 32'hF000_0001, 32'h0, 1, 32'h40, 4'hF, 32'h0, 32'h0, 32'h0, 64'hF000_0001, 1'b0, 2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'b111, 64'h50, 64'h0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 64'h0, 1'b0, 1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b010, 64'h60, 64'h0, 1000, 32'h0, 32'h0, 1, 32'h60, 4'hF, 32'h0, 32'h0, 32'h0, 64'h0, 1'b0, 17, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 3'b000, 64'h201, 64'h0, 0, 32'h0000_7F00, 32'h0, 1, 32'h200, 4'b0010, 32'h0, 32'h0, 32'h0, 64'h7F, 1'b0, 2, 1'b0, 1'b0};

    reset = 1'b1; data_mem_read_en = 1'b0; data_mem_write_en = 1'b0;
    inst_funct3 = 3'b000; address = 64'h0; write_data = 64'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0; model_rd = 64'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bus_req", {63'h0, bus_req}, 64'h0);
    check("rst_mem_done", {63'h0, mem_done}, 64'h0);
    check("rst_mem_busy", {63'h0, mem_busy}, 64'h0);
    check("rst_bus_error", {63'h0, bus_error}, 64'h0);
    check("rst_read_data", read_data, 64'h0);
    check("rst_bus_addr", {32'h0, bus_addr}, 64'h0);
    check("rst_bus_be", {60'h0, bus_be}, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 1'b0);

    // Enables held through DONE: the next cycle must not start another beat.
    run_vec(vecs[2], 1'b1);

    // Reset while the second beat of a doubleword load is outstanding.
    @(negedge clock);
    data_mem_read_en = 1'b1; inst_funct3 = 3'b011; address = 64'h3000; write_data = 64'h0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    check("rst_seq_beat0_req", {63'h0, bus_req}, 64'h1);
    @(posedge clock); #1;
    check("rst_seq_beat1_req", {63'h0, bus_req}, 64'h1);
    check("rst_seq_beat1_addr", {32'h0, bus_addr}, 64'h3004);
    @(negedge clock);
    reset = 1'b1; data_mem_read_en = 1'b0; bus_ack = 1'b0;
    @(posedge clock); #1;
    check("rst_seq_req_dropped", {63'h0, bus_req}, 64'h0);
    check("rst_seq_busy", {63'h0, mem_busy}, 64'h0);
    check("rst_seq_done", {63'h0, mem_done}, 64'h0);
    check("rst_seq_read_data", read_data, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    model_rd = 64'h0;
    repeat (2) begin
      @(posedge clock); #1;
      check("rst_seq_stays_idle", {63'h0, bus_req}, 64'h0);
    end
    run_vec(vecs[1], 1'b0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
